// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch stage. Holds the PC, issues one-at-a-time
//                requests to instruction memory over req/ack, buffers the
//                returned words in a small FIFO and hands {instr, pc} plus the
//                decoded opcode/funct3/funct7 fields to decode over
//                valid/ready. A taken branch flushes buffered instructions and
//                discards any fetch already in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk_in,
    input  logic            reset_in,
    // redirect
    input  logic            branchTaken_in,
    input  logic [XLEN-1:0] branchTarget_in,
    // instruction memory
    output logic            imemReq_out,
    output logic [XLEN-1:0] imemAddr_out,
    input  logic            imemAck_in,
    input  logic [31:0]     imemData_in,
    // decode
    output logic            instrValid_out,
    input  logic            decodeReady_in,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instrPc_out,
    output logic [6:0]      opcode_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      funct7_out
);

    localparam int              c_ptr_w     = $clog2(BUF_DEPTH);
    localparam int              c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(BUF_DEPTH);
    localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);
    localparam logic [XLEN-1:0] c_align_msk = ~XLEN'(3);

    // IDLE : no request outstanding
    // FETCH: request outstanding, result will be kept
    // DROP : request outstanding, result will be discarded (redirected)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     w_pc_next;
    logic [XLEN-1:0]     r_addr;
    logic                r_req;

    logic [31:0]         r_buf_instr [BUF_DEPTH];
    logic [XLEN-1:0]     r_buf_pc    [BUF_DEPTH];
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_head_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic [c_cnt_w-1:0]  w_count_post;
    logic [XLEN-1:0]     w_target;

    // Only a fetch that is still wanted (no redirect this cycle) is buffered.
    assign w_head_valid = (r_count != '0);
    assign w_push       = (r_state == S_FETCH) && imemAck_in && !branchTaken_in;
    assign w_pop        = w_head_valid && decodeReady_in;
    assign w_flush      = branchTaken_in;
    assign w_count_post = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_target     = branchTarget_in & c_align_msk;

    // Next-state and next-PC selection.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (branchTaken_in) begin
                    w_pc_next    = w_target;
                    w_state_next = S_FETCH;
                end else if (r_count < c_depth) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (branchTaken_in) begin
                    // Returned data this cycle is simply not pushed; without an
                    // ack the old request must still be retired before refetch.
                    w_pc_next    = w_target;
                    w_state_next = imemAck_in ? S_FETCH : S_DROP;
                end else if (imemAck_in) begin
                    w_pc_next    = r_pc + c_pc_step;
                    w_state_next = (w_count_post < c_depth) ? S_FETCH : S_IDLE;
                end
            end
            S_DROP: begin
                if (branchTaken_in) begin
                    w_pc_next = w_target;
                end
                if (imemAck_in) begin
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Fetch FSM state, PC and registered memory request outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_req   <= (w_state_next != S_IDLE);
            // While dropping, the address of the abandoned request is held
            // stable until memory acknowledges it.
            if (w_state_next == S_DROP) begin
                r_addr <= r_addr;
            end else begin
                r_addr <= w_pc_next;
            end
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_post;
        end
    end

    // Buffer storage; contents are only observed through the occupancy count.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_buf_instr[r_wptr] <= imemData_in;
            r_buf_pc[r_wptr]    <= r_pc;
        end
    end

    assign imemReq_out    = r_req;
    assign imemAddr_out   = r_addr;
    assign instrValid_out = w_head_valid;
    assign instr_out      = w_head_valid ? r_buf_instr[r_rptr] : 32'h0;
    assign instrPc_out    = w_head_valid ? r_buf_pc[r_rptr]    : '0;
    assign opcode_out     = instr_out[6:0];
    assign funct3_out     = instr_out[14:12];
    assign funct7_out     = instr_out[31:25];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit.
//                Memory returns {16'hC0DE, addr[15:0]} unless a fixed word
//                is selected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int XLEN = 64;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic            branchTaken_in;
    logic [XLEN-1:0] branchTarget_in;
    logic            imemReq_out;
    logic [XLEN-1:0] imemAddr_out;
    logic            imemAck_in;
    logic [31:0]     imemData_in;
    logic            instrValid_out;
    logic            decodeReady_in;
    logic [31:0]     instr_out;
    logic [XLEN-1:0] instrPc_out;
    logic [6:0]      opcode_out;
    logic [2:0]      funct3_out;
    logic [6:0]      funct7_out;

    logic            use_fixed;
    logic [31:0]     fixed_data;

    int errors = 0;
    int checks = 0;

    assign imemData_in = use_fixed ? fixed_data : {16'hC0DE, imemAddr_out[15:0]};

    always #5 clk_in = ~clk_in;

    instr_fetch_unit #(
        .XLEN      (XLEN),
        .RESET_PC  (64'h0),
        .BUF_DEPTH (2)
    ) u_dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .branchTaken_in  (branchTaken_in),
        .branchTarget_in (branchTarget_in),
        .imemReq_out     (imemReq_out),
        .imemAddr_out    (imemAddr_out),
        .imemAck_in      (imemAck_in),
        .imemData_in     (imemData_in),
        .instrValid_out  (instrValid_out),
        .decodeReady_in  (decodeReady_in),
        .instr_out       (instr_out),
        .instrPc_out     (instrPc_out),
        .opcode_out      (opcode_out),
        .funct3_out      (funct3_out),
        .funct7_out      (funct7_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Reset held for two edges, released 1 time unit after an edge.
    task automatic do_reset();
        reset_in        = 1'b1;
        branchTaken_in  = 1'b0;
        branchTarget_in = '0;
        imemAck_in      = 1'b0;
        decodeReady_in  = 1'b0;
        use_fixed       = 1'b0;
        fixed_data      = 32'h0;
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imemReq_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h expected 0", imemReq_out); end
        checks++; if (imemAddr_out !== 64'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", imemAddr_out); end
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", instrValid_out); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %0h expected 0", instr_out); end
        checks++; if (instrPc_out !== 64'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", instrPc_out); end
        step();
        checks++; if (imemReq_out !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %0h expected 1", imemReq_out); end
    endtask

    task automatic test_stream();
        logic [XLEN-1:0] exp_pc;
        do_reset();
        imemAck_in     = 1'b1;
        decodeReady_in = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            checks++; if (imemReq_out !== 1'b1) begin errors++; $display("FAIL stream_req[%0d]: got %0h expected 1", k, imemReq_out); end
            checks++; if (imemAddr_out !== XLEN'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got %0h expected %0h", k, imemAddr_out, 4 * k); end
            if (k == 0) begin
                checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL stream_valid0: got %0h expected 0", instrValid_out); end
            end else begin
                exp_pc = XLEN'(4 * (k - 1));
                checks++; if (instrValid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0h expected 1", k, instrValid_out); end
                checks++; if (instrPc_out !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %0h expected %0h", k, instrPc_out, exp_pc); end
                checks++; if (instr_out !== {16'hC0DE, exp_pc[15:0]}) begin errors++; $display("FAIL stream_instr[%0d]: got %0h expected %0h", k, instr_out, {16'hC0DE, exp_pc[15:0]}); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imemAck_in     = 1'b1;
        decodeReady_in = 1'b0;
        step();  // request for 0
        step();  // request for 4, head pc 0
        checks++; if (imemAddr_out !== 64'h4) begin errors++; $display("FAIL bp_addr4: got %0h expected 4", imemAddr_out); end
        step();  // buffer full
        checks++; if (imemReq_out !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %0h expected 0", imemReq_out); end
        checks++; if (instrPc_out !== 64'h0) begin errors++; $display("FAIL bp_head0: got %0h expected 0", instrPc_out); end
        step();
        checks++; if (imemReq_out !== 1'b0) begin errors++; $display("FAIL bp_req_hold: got %0h expected 0", imemReq_out); end
        decodeReady_in = 1'b1;
        step();  // head 0 consumed
        checks++; if (instrPc_out !== 64'h4) begin errors++; $display("FAIL bp_head4: got %0h expected 4", instrPc_out); end
        checks++; if (instr_out !== 32'hC0DE0004) begin errors++; $display("FAIL bp_instr4: got %0h expected c0de0004", instr_out); end
        step();  // head 4 consumed, fetch resumes
        checks++; if (imemReq_out !== 1'b1) begin errors++; $display("FAIL bp_resume_req: got %0h expected 1", imemReq_out); end
        checks++; if (imemAddr_out !== 64'h8) begin errors++; $display("FAIL bp_resume_addr: got %0h expected 8", imemAddr_out); end
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0h expected 0", instrValid_out); end
    endtask

    task automatic test_delayed_ack();
        do_reset();
        imemAck_in     = 1'b0;
        decodeReady_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (imemReq_out !== 1'b1) begin errors++; $display("FAIL dly_req[%0d]: got %0h expected 1", k, imemReq_out); end
            checks++; if (imemAddr_out !== 64'h0) begin errors++; $display("FAIL dly_addr[%0d]: got %0h expected 0", k, imemAddr_out); end
            checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL dly_valid[%0d]: got %0h expected 0", k, instrValid_out); end
        end
        imemAck_in = 1'b1;
        step();
        imemAck_in = 1'b0;
        checks++; if (instrValid_out !== 1'b1) begin errors++; $display("FAIL dly_push: got %0h expected 1", instrValid_out); end
        checks++; if (imemAddr_out !== 64'h4) begin errors++; $display("FAIL dly_next_addr: got %0h expected 4", imemAddr_out); end
        step();
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL dly_single_push: got %0h expected 0", instrValid_out); end
    endtask

    task automatic test_branch_drop();
        do_reset();
        imemAck_in     = 1'b1;
        decodeReady_in = 1'b1;
        step(); step(); step();  // request for 8 outstanding
        checks++; if (imemAddr_out !== 64'h8) begin errors++; $display("FAIL drop_pre_addr: got %0h expected 8", imemAddr_out); end
        imemAck_in      = 1'b0;
        branchTaken_in  = 1'b1;
        branchTarget_in = 64'h100;
        step();
        branchTaken_in = 1'b0;
        checks++; if (imemReq_out !== 1'b1) begin errors++; $display("FAIL drop_req: got %0h expected 1", imemReq_out); end
        checks++; if (imemAddr_out !== 64'h8) begin errors++; $display("FAIL drop_addr_hold: got %0h expected 8", imemAddr_out); end
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL drop_flushed: got %0h expected 0", instrValid_out); end
        step();
        checks++; if (imemAddr_out !== 64'h8) begin errors++; $display("FAIL drop_addr_hold2: got %0h expected 8", imemAddr_out); end
        imemAck_in = 1'b1;  // late data for 0x8 is discarded
        step();
        checks++; if (imemAddr_out !== 64'h100) begin errors++; $display("FAIL drop_target_addr: got %0h expected 100", imemAddr_out); end
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL drop_discard: got %0h expected 0", instrValid_out); end
        step();
        checks++; if (instrPc_out !== 64'h100) begin errors++; $display("FAIL drop_first_pc: got %0h expected 100", instrPc_out); end
        checks++; if (instr_out !== 32'hC0DE0100) begin errors++; $display("FAIL drop_first_instr: got %0h expected c0de0100", instr_out); end
        checks++; if (imemAddr_out !== 64'h104) begin errors++; $display("FAIL drop_next_addr: got %0h expected 104", imemAddr_out); end
    endtask

    task automatic test_branch_with_ack();
        do_reset();
        imemAck_in     = 1'b1;
        decodeReady_in = 1'b1;
        step(); step();
        branchTaken_in  = 1'b1;
        branchTarget_in = 64'h203;
        step();
        branchTaken_in = 1'b0;
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL bra_empty: got %0h expected 0", instrValid_out); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL bra_instr0: got %0h expected 0", instr_out); end
        checks++; if (imemAddr_out !== 64'h200) begin errors++; $display("FAIL bra_addr: got %0h expected 200", imemAddr_out); end
        checks++; if (imemReq_out !== 1'b1) begin errors++; $display("FAIL bra_req: got %0h expected 1", imemReq_out); end
        step();
        checks++; if (instrPc_out !== 64'h200) begin errors++; $display("FAIL bra_first_pc: got %0h expected 200", instrPc_out); end
        checks++; if (imemAddr_out !== 64'h204) begin errors++; $display("FAIL bra_next_addr: got %0h expected 204", imemAddr_out); end
    endtask

    task automatic test_decode_fields();
        do_reset();
        decodeReady_in = 1'b0;
        step();
        use_fixed  = 1'b1;
        fixed_data = 32'h00A30333;
        imemAck_in = 1'b1;
        step();
        fixed_data = 32'hFE0F9FE3;
        checks++; if (instr_out !== 32'h00A30333) begin errors++; $display("FAIL fld_instr_add: got %0h expected 00a30333", instr_out); end
        checks++; if (opcode_out !== 7'h33) begin errors++; $display("FAIL fld_opcode_add: got %0h expected 33", opcode_out); end
        checks++; if (funct3_out !== 3'h0) begin errors++; $display("FAIL fld_funct3_add: got %0h expected 0", funct3_out); end
        checks++; if (funct7_out !== 7'h00) begin errors++; $display("FAIL fld_funct7_add: got %0h expected 0", funct7_out); end
        step();
        imemAck_in     = 1'b0;
        decodeReady_in = 1'b1;
        step();
        checks++; if (opcode_out !== 7'h63) begin errors++; $display("FAIL fld_opcode_br: got %0h expected 63", opcode_out); end
        checks++; if (funct3_out !== 3'h1) begin errors++; $display("FAIL fld_funct3_br: got %0h expected 1", funct3_out); end
        checks++; if (funct7_out !== 7'h7F) begin errors++; $display("FAIL fld_funct7_br: got %0h expected 7f", funct7_out); end
        checks++; if (instrPc_out !== 64'h4) begin errors++; $display("FAIL fld_pc_br: got %0h expected 4", instrPc_out); end
        use_fixed = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        imemAck_in     = 1'b1;
        decodeReady_in = 1'b0;
        step(); step();
        imemAck_in = 1'b0;
        checks++; if (imemAddr_out !== 64'h4) begin errors++; $display("FAIL ar_pre_addr: got %0h expected 4", imemAddr_out); end
        #2;
        reset_in = 1'b1;
        #1;
        checks++; if (imemReq_out !== 1'b0) begin errors++; $display("FAIL ar_req: got %0h expected 0", imemReq_out); end
        checks++; if (imemAddr_out !== 64'h0) begin errors++; $display("FAIL ar_addr: got %0h expected 0", imemAddr_out); end
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL ar_valid: got %0h expected 0", instrValid_out); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL ar_instr: got %0h expected 0", instr_out); end
        checks++; if (instrPc_out !== 64'h0) begin errors++; $display("FAIL ar_pc: got %0h expected 0", instrPc_out); end
        checks++; if (opcode_out !== 7'h0) begin errors++; $display("FAIL ar_opcode: got %0h expected 0", opcode_out); end
        imemAck_in = 1'b1;  // late ack from the abandoned request
        #1;
        reset_in = 1'b0;
        step();
        checks++; if (instrValid_out !== 1'b0) begin errors++; $display("FAIL ar_late_ack: got %0h expected 0", instrValid_out); end
        checks++; if (imemAddr_out !== 64'h0) begin errors++; $display("FAIL ar_restart_addr: got %0h expected 0", imemAddr_out); end
        checks++; if (imemReq_out !== 1'b1) begin errors++; $display("FAIL ar_restart_req: got %0h expected 1", imemReq_out); end
        step();
        checks++; if (instr_out !== 32'hC0DE0000) begin errors++; $display("FAIL ar_first_instr: got %0h expected c0de0000", instr_out); end
    endtask

    initial begin
        reset_in        = 1'b1;
        branchTaken_in  = 1'b0;
        branchTarget_in = '0;
        imemAck_in      = 1'b0;
        decodeReady_in  = 1'b0;
        use_fixed       = 1'b0;
        fixed_data      = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_delayed_ack();
        test_branch_drop();
        test_branch_with_ack();
        test_decode_fields();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
